// File: rtl/vending_pkg.sv
// Shared vending-machine definitions: button channel indices and
// default debounce length for the input conditioning stage.
package vending_pkg;

  localparam int unsigned BTN_COIN1     = 32'd0;
  localparam int unsigned BTN_COIN2     = 32'd1;
  localparam int unsigned BTN_COIN5     = 32'd2;
  localparam int unsigned BTN_COIN10    = 32'd3;
  localparam int unsigned BTN_SEL1      = 32'd4;
  localparam int unsigned BTN_SEL2      = 32'd5;
  localparam int unsigned BTN_SEL5      = 32'd6;
  localparam int unsigned BTN_SEL10     = 32'd7;
  localparam int unsigned BTN_CONFIRM   = 32'd8;
  localparam int unsigned BTN_RST_TOTAL = 32'd9;

  localparam int unsigned N_BTN = 32'd10;

  // 20 ms at 50 MHz
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 32'd1000000;

  typedef logic [N_BTN-1:0] btn_vec_t;

endpackage

// File: rtl/debounce_cell.sv
// Single-bit two-flop synchroniser plus debounce counter; exposes the
// accepted (stable) level and a registered one-cycle rising-edge pulse.
module debounce_cell #(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd4,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_stable;
  logic             r_rise;
  logic             w_diff;
  logic             w_done;

  assign w_diff = r_sync2 ^ r_stable;
  // The count saturates here and is cleared in the same edge, so it never wraps.
  assign w_done = w_diff && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 32'd1));

  // Synchroniser, debounce counter, accepted level and rise pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_cnt    <= '0;
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_rise <= w_done && r_sync2;
    end
  end

  assign o_level = r_stable;
  assign o_rise  = r_rise;

endmodule

// File: rtl/button_conditioner.sv
// Debounces every raw button, emits one press pulse per accepted press and
// keeps a sticky event/overrun flag per button until the consumer acks it.
module button_conditioner #(
  parameter int unsigned N_BTN           = vending_pkg::N_BTN,
  parameter int unsigned DEBOUNCE_CYCLES = vending_pkg::DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_BTN-1:0] ack,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] btn_event,
  output logic [N_BTN-1:0] overrun
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [N_BTN-1:0] w_level;
  logic [N_BTN-1:0] w_pulse;
  logic [N_BTN-1:0] w_event_nxt;
  logic [N_BTN-1:0] w_overrun_nxt;
  logic [N_BTN-1:0] r_event;
  logic [N_BTN-1:0] r_overrun;

  for (genvar g = 0; g < N_BTN; g++) begin : g_cell
    debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .i_raw   (btn_raw[g]),
      .o_level (w_level[g]),
      .o_rise  (w_pulse[g])
    );
  end

  // Event/overrun next state: a new press outranks a same-cycle ack so it is never lost.
  always_comb begin
    w_event_nxt   = r_event;
    w_overrun_nxt = r_overrun;
    for (int i = 0; i < N_BTN; i++) begin
      if (w_pulse[i]) begin
        w_event_nxt[i] = 1'b1;
        if (r_event[i] && !ack[i]) begin
          w_overrun_nxt[i] = 1'b1;
        end else begin
          w_overrun_nxt[i] = r_overrun[i];
        end
      end else if (ack[i]) begin
        w_event_nxt[i]   = 1'b0;
        w_overrun_nxt[i] = 1'b0;
      end else begin
        w_event_nxt[i]   = r_event[i];
        w_overrun_nxt[i] = r_overrun[i];
      end
    end
  end

  // Sticky flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_event   <= '0;
      r_overrun <= '0;
    end else begin
      r_event   <= w_event_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  assign btn_level = w_level;
  assign btn_pulse = w_pulse;
  assign btn_event = r_event;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: a window-based reference model predicts every output each
// cycle; a negedge monitor pops and compares. Directed and random stimulus.
module tb_button_conditioner;

  localparam int unsigned D  = 32'd4;
  localparam int unsigned NB = vending_pkg::N_BTN;

  typedef struct packed {
    logic [NB-1:0] lvl;
    logic [NB-1:0] pls;
    logic [NB-1:0] ev;
    logic [NB-1:0] ov;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] ack = '0;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_pulse;
  logic [NB-1:0] btn_event;
  logic [NB-1:0] overrun;

  int checks = 0;
  int errors = 0;

  exp_t          sb_q[$];
  logic [NB-1:0] raw_q[$];
  logic [NB-1:0] sync_hist[$];
  logic [NB-1:0] m_stable = '0;
  logic [NB-1:0] m_pulse = '0;
  logic [NB-1:0] m_ev = '0;
  logic [NB-1:0] m_ov = '0;

  button_conditioner #(
    .N_BTN           (NB),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .ack       (ack),
    .btn_level (btn_level),
    .btn_pulse (btn_pulse),
    .btn_event (btn_event),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [NB-1:0] got, input logic [NB-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h exp %h", nm, $time, got, exp);
    end
  endtask

  // Reference model: sync is raw delayed two edges; a level is accepted once the
  // last D synchronised samples all disagree with the current accepted level.
  always @(posedge clk) begin : model
    logic [NB-1:0] sync_v;
    logic [NB-1:0] new_pulse;
    logic [NB-1:0] ev_n;
    logic [NB-1:0] ov_n;
    logic          all_diff;
    if (!rst) begin
      m_stable = '0;
      m_pulse  = '0;
      m_ev     = '0;
      m_ov     = '0;
      raw_q.delete();
      raw_q.push_back('0);
      raw_q.push_back('0);
      sync_hist.delete();
    end else begin
      raw_q.push_back(btn_raw);
      sync_v = raw_q.pop_front();
      sync_hist.push_back(sync_v);
      if (sync_hist.size() > D) void'(sync_hist.pop_front());
      new_pulse = '0;
      for (int i = 0; i < NB; i++) begin
        all_diff = (sync_hist.size() == D);
        foreach (sync_hist[k]) begin
          if (sync_hist[k][i] == m_stable[i]) all_diff = 1'b0;
        end
        if (all_diff) begin
          m_stable[i]  = ~m_stable[i];
          new_pulse[i] = m_stable[i];
        end
      end
      ev_n = m_ev;
      ov_n = m_ov;
      for (int i = 0; i < NB; i++) begin
        if (m_pulse[i]) begin
          ev_n[i] = 1'b1;
          if (m_ev[i] && !ack[i]) ov_n[i] = 1'b1;
        end else if (ack[i]) begin
          ev_n[i] = 1'b0;
          ov_n[i] = 1'b0;
        end
      end
      m_ev    = ev_n;
      m_ov    = ov_n;
      m_pulse = new_pulse;
    end
    sb_q.push_back({m_stable, m_pulse, m_ev, m_ov});
  end

  // Monitor: outputs are presented every cycle; compare on the falling edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("level",   btn_level, e.lvl);
      chk("pulse",   btn_pulse, e.pls);
      chk("event",   btn_event, e.ev);
      chk("overrun", overrun,   e.ov);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic press_release(input int b);
    btn_raw[b] = 1'b1;
    step(9);
    btn_raw[b] = 1'b0;
    step(9);
  endtask

  initial begin
    // Reset with all buttons held, then release
    btn_raw = '1;
    step(3);
    rst = 1'b1;
    step(6);
    chk("rst_pulse_all", btn_pulse, {NB{1'b1}});
    step(4);
    ack = '1;
    step(1);
    ack = '0;
    btn_raw = '0;
    step(10);

    // Clean press on bit 0
    btn_raw[0] = 1'b1;
    step(10);

    // Bounce on bit 4, then a 3-cycle glitch on bit 5
    btn_raw[4] = 1'b1; step(1);
    btn_raw[4] = 1'b0; step(1);
    btn_raw[4] = 1'b1; step(1);
    btn_raw[4] = 1'b0; step(1);
    btn_raw[4] = 1'b1; step(10);
    btn_raw[5] = 1'b1; step(3);
    btn_raw[5] = 1'b0; step(8);

    // Handshake and overrun on bit 8
    btn_raw[8] = 1'b1; step(8);
    ack[8] = 1'b1; step(1);
    ack[8] = 1'b0;
    btn_raw[8] = 1'b0; step(8);
    press_release(8);
    press_release(8);
    ack[8] = 1'b1; step(1);
    ack[8] = 1'b0; step(2);

    // Bit 2: build event+overrun, then ack exactly on the next pulse cycle
    press_release(2);
    press_release(2);
    btn_raw[2] = 1'b1;
    step(6);
    chk("ack_align_pulse", btn_pulse & 10'h004, 10'h004);
    ack[2] = 1'b1; step(1);
    ack[2] = 1'b0;
    chk("pulse_ack_event", btn_event & 10'h004, 10'h004);
    chk("pulse_ack_ovr",   overrun & 10'h004,   10'h004);
    step(3);

    // Simultaneous presses on bits 1 and 3
    btn_raw[1] = 1'b1;
    btn_raw[3] = 1'b1;
    step(12);

    // Random bouncy activity with random acks
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NB; i++) begin
        if ($urandom_range((c < 400) ? 3 : 9, 0) == 0) btn_raw[i] = ~btn_raw[i];
        ack[i] = ($urandom_range(7, 0) == 0);
      end
      step(1);
    end
    ack = '0;

    // Reset in the middle of activity with buttons held through release
    btn_raw = '1;
    step(2);
    rst = 1'b0;
    step(3);
    rst = 1'b1;
    step(12);
    btn_raw = '0;
    step(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Input-conditioning stage directly upstream of the vending control logic.
- Takes raw, bouncy, asynchronous push-button levels (coin1/2/5/10, select1/2/5/10, confirm, resetTotal), synchronises and debounces each one, and emits a clean one-cycle press pulse.
- Also holds a sticky event flag per button until the consumer acknowledges it, so a controller on a slower enable or tick can never miss a press.

Parameters:
- N_BTN, 10, number of button channels (bit index = button ID from the shared package).
- DEBOUNCE_CYCLES, 1000000, consecutive clk cycles a synchronised level must stay changed before it is accepted (20 ms at 50 MHz); must be ≥2.
- CNT_W, $clog2(DEBOUNCE_CYCLES), debounce counter width (derived).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- btn_raw  input  N_BTN  raw button levels, active-high, asynchronous to clk.
- ack  input  N_BTN  per-button acknowledge, one clk pulse, clears the matching event/overrun.
- btn_level  output  N_BTN  debounced button level.
- btn_pulse  output  N_BTN  one-cycle pulse on each debounced rising edge.
- btn_event  output  N_BTN  sticky "press pending" flag.
- overrun  output  N_BTN  sticky "press arrived while event still pending".

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. Reset asserts immediately and is released synchronously by the surrounding reset logic.
- Reset values: all outputs 0, synchroniser flops 0, stable levels 0, counters 0.
- Synchroniser: two-flop per bit; sync = second flop. Raw→sync latency is 2 clk.
- Debounce, per channel independently:
  - If sync == stable: counter <= 0.
  - Else: counter increments.
  - When the counter == DEBOUNCE_CYCLES-1 and sync still != stable: stable <= sync, counter <= 0.
  - Any glitch back to stable before the count completes restarts the counter at 0.
  - Release (1→0) is debounced identically.
- btn_level = stable, registered. A clean press is visible on btn_level DEBOUNCE_CYCLES+2 clk after the raw edge.
- btn_pulse: high for exactly one clk in the cycle stable goes 0→1. Nothing is emitted on release. Holding the button produces no further pulses.
- btn_event, per bit, priority top-down:
  - Pulse this cycle: event <= 1.
  - Else ack: event <= 0.
  - Else hold.
  - Pulse and ack in the same cycle leaves the event at 1, so the new press is not lost.
- overrun: set when a pulse occurs while event is already 1 and there is no same-cycle ack. Cleared only by ack. If set and ack arrive together, set wins.
- ack while event=0: no effect, no error.
- Simultaneous presses on several channels: all are reported independently. This block does no priority or exclusion; arbitration belongs to the consumer.
- Reset mid-debounce: the counter and stable level are discarded. A button held through reset release is re-debounced and yields one pulse once it is stable.
- Counter never exceeds DEBOUNCE_CYCLES-1; there is no wrap-around path.

Decomposition:
- Shared package vending_pkg holds:
  - Button index constants: BTN_COIN1=0, BTN_COIN2=1, BTN_COIN5=2, BTN_COIN10=3, BTN_SEL1=4, BTN_SEL2=5, BTN_SEL5=6, BTN_SEL10=7, BTN_CONFIRM=8, BTN_RST_TOTAL=9.
  - N_BTN=10.
  - DEBOUNCE_CYCLES_DEFAULT.
- One sub-module, debounce_cell: a single-bit synchroniser, counter and stable register, with outputs level and rise. It is instantiated N_BTN times in a generate loop. The event and overrun logic stays in the top of this block.

Test Plan (DEBOUNCE_CYCLES=4 for all):
- Reset: hold rst=0 with btn_raw=all 1s → all outputs 0; release rst → btn_pulse[i] fires once per bit 6 clk after release, and btn_event becomes all 1s.
- Clean press: btn_raw[0] 0→1 held → btn_pulse[0] high exactly 1 clk, 6 clk after the edge; btn_level[0]=1 and btn_event[0]=1 from then on; other bits stay 0.
- Bounce: btn_raw[4] toggles 1,0,1,0 on consecutive clk, then holds 1 → a single btn_pulse[4] 6 clk after the final rising edge; a 3-clk high glitch alone gives no pulse.
- Handshake: event[8]=1, ack[8] pulse → event[8]=0 next clk; second press before ack → overrun[8]=1; ack clears both.
- Same-cycle pulse and ack on bit 2 → event[2] remains 1 and overrun[2] is unchanged.
- Simultaneous: btn_raw[1] and btn_raw[3] rise on the same clk → both pulses in the same cycle, both events set.
